// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU data port.
// Byte-addressed, little-endian storage with a fixed access latency.
// Handles RV32 sub-word loads (sign/zero extension) and sub-word stores.
// Misaligned, unused-funct3, bad-size and read+write accesses are flagged
// with a one-cycle ERR pulse that coincides with completion.
//
// Handshake: the CPU holds READ[3] or WRITE[2] (the request) together with
// stable operands. BUSYWAIT is high while that request is outstanding. The
// cycle in which BUSYWAIT is low with the request still held is the
// completion cycle (DONE). READ_DATA and ERR are valid in that cycle, and
// the CPU drops its request on the following edge. Operands are captured
// when the request is accepted, so later changes are ignored.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  DATA_MEM_READ,
  input  logic [2:0]  DATA_MEM_WRITE,
  input  logic [31:0] DATA_MEM_ADDR,
  input  logic [31:0] DATA_MEM_WRITE_DATA,
  output logic [31:0] DATA_MEM_READ_DATA,
  output logic        DATA_MEM_BUSYWAIT,
  output logic        DATA_MEM_ERR,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      f3_q;
  logic [1:0]      size_q;
  logic            rd_q;
  logic            wr_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [7:0]      mem [DEPTH];

  logic            req;
  logic            access;
  logic [AW-1:0]   wbase;
  logic [7:0]      rb [4];
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     word_v;
  logic [31:0]     load_val;
  logic            load_err;
  logic [3:0]      st_be;
  logic [3:0][7:0] st_lane;
  logic            st_err;
  logic            unused_addr_hi;

  assign req    = DATA_MEM_READ[3] | DATA_MEM_WRITE[2];
  // The access itself happens on the edge that ends the last WAIT cycle.
  assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);
  // Both sub-word loads and stores work on the aligned word containing the
  // address; dropped low bits only select lanes or flag misalignment.
  assign wbase  = addr_q & ~AW'(3);

  // Address bits above the storage size simply wrap.
  assign unused_addr_hi = ^DATA_MEM_ADDR[31:AW];

  // Fetch the four byte lanes of the addressed word.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rb[k] = mem[wbase | AW'(k)];
    end
  end

  // Load result selection and extension from the latched funct3.
  always_comb begin
    byte_v   = rb[addr_q[1:0]];
    half_v   = {rb[{addr_q[1], 1'b1}], rb[{addr_q[1], 1'b0}]};
    word_v   = {rb[3], rb[2], rb[1], rb[0]};
    load_val = '0;
    load_err = 1'b0;
    case (f3_q)
      3'b000: load_val = {{24{byte_v[7]}}, byte_v};
      3'b100: load_val = {24'd0, byte_v};
      3'b001: begin
        load_val = {{16{half_v[15]}}, half_v};
        load_err = addr_q[0];
      end
      3'b101: begin
        load_val = {16'd0, half_v};
        load_err = addr_q[0];
      end
      3'b010: begin
        load_val = word_v;
        load_err = |addr_q[1:0];
      end
      default: load_err = 1'b1;
    endcase
  end

  // Store lane enables; data is replicated so each enabled lane gets its byte.
  always_comb begin
    st_be   = 4'b0000;
    st_lane = wdata_q;
    st_err  = 1'b0;
    case (size_q)
      2'b00: begin
        st_be[addr_q[1:0]] = 1'b1;
        st_lane            = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_lane = {2{wdata_q[15:0]}};
        st_err  = addr_q[0];
      end
      2'b10: begin
        st_be  = 4'b1111;
        st_err = |addr_q[1:0];
      end
      default: st_err = 1'b1;
    endcase
  end

  // Storage write port; contents survive reset, and reset forces IDLE so an
  // interrupted access never reaches this write.
  always_ff @(posedge CLK) begin
    if (access && wr_q) begin
      for (int k = 0; k < 4; k++) begin
        if (st_be[k]) begin
          mem[wbase | AW'(k)] <= st_lane[k];
        end
      end
    end
  end

  // Request FSM: accept and latch in IDLE, count down in WAIT, one-cycle DONE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'd0;
      size_q  <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= DATA_MEM_ADDR[AW-1:0];
            wdata_q <= DATA_MEM_WRITE_DATA;
            f3_q    <= DATA_MEM_READ[2:0];
            size_q  <= DATA_MEM_WRITE[1:0];
            rd_q    <= DATA_MEM_READ[3];
            wr_q    <= DATA_MEM_WRITE[2];
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            if (wr_q) begin
              // A write wins over a simultaneous read, which is an error.
              err_q <= st_err | rd_q;
            end else begin
              rdata_q <= load_val;
              err_q   <= load_err;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // BUSYWAIT is gated by reset so it drops the moment reset is applied.
  assign DATA_MEM_BUSYWAIT  = req & (state_q != S_DONE) & RESET_N;
  assign DATA_MEM_READ_DATA = rdata_q;
  assign DATA_MEM_ERR       = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed accesses, randomized traffic checked
// against a byte-array reference model, and a reset in the middle of a store.
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit   [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_rdata = 32'd0;
  logic [32:0] exp_q[$];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK                 (clk),
    .RESET_N             (rst_n),
    .DATA_MEM_READ       (mem_read),
    .DATA_MEM_WRITE      (mem_write),
    .DATA_MEM_ADDR       (mem_addr),
    .DATA_MEM_WRITE_DATA (mem_wdata),
    .DATA_MEM_READ_DATA  (mem_rdata),
    .DATA_MEM_BUSYWAIT   (mem_busy),
    .DATA_MEM_ERR        (mem_err),
    .dbg_state_o         (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: applies one access to ref_mem / ref_rdata and
  // returns the expected error flag.
  task automatic model_access(input logic [3:0] rd_v, input logic [2:0] wr_v,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output bit e_err);
    int unsigned ea;
    int unsigned nb;
    int unsigned base;
    bit          sgn;
    logic [31:0] v;
    ea    = addr % DEPTH;
    e_err = 1'b0;
    if (wr_v[2]) begin
      case (wr_v[1:0])
        2'b00:   nb = 1;
        2'b01:   nb = 2;
        2'b10:   nb = 4;
        default: nb = 0;
      endcase
      if (nb == 0) begin
        e_err = 1'b1;
      end else begin
        base  = ea - (ea % nb);
        e_err = (ea % nb) != 0;
        for (int i = 0; i < int'(nb); i++) ref_mem[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end
      if (rd_v[3]) e_err = 1'b1;
    end else begin
      sgn = 1'b0;
      case (rd_v[2:0])
        3'b000: begin nb = 1; sgn = 1'b1; end
        3'b001: begin nb = 2; sgn = 1'b1; end
        3'b010: nb = 4;
        3'b100: nb = 1;
        3'b101: nb = 2;
        default: nb = 0;
      endcase
      if (nb == 0) begin
        ref_rdata = 32'd0;
        e_err     = 1'b1;
      end else begin
        base  = ea - (ea % nb);
        e_err = (ea % nb) != 0;
        v     = 32'd0;
        for (int i = 0; i < int'(nb); i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (sgn && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        ref_rdata = v;
      end
    end
  endtask

  // Driver: issue one access, hold it until BUSYWAIT is sampled low,
  // check the completion cycle, then release the request.
  task automatic do_access(input logic [3:0] rd_v, input logic [2:0] wr_v,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input bit scramble, output logic [31:0] got_rd,
                           output logic got_err);
    bit          e_err;
    bit          done;
    int          busy_n;
    logic [32:0] exp_v;
    model_access(rd_v, wr_v, addr, wd, e_err);
    exp_q.push_back({e_err, ref_rdata});
    mem_read  = rd_v;
    mem_write = wr_v;
    mem_addr  = addr;
    mem_wdata = wd;
    busy_n    = 0;
    done      = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_busy) begin
        busy_n++;
        if (scramble && busy_n >= 2) begin
          mem_addr  = $urandom;
          mem_wdata = $urandom;
        end
      end else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("busy_timeout", 32'd1, 32'd0);
    got_rd  = mem_rdata;
    got_err = mem_err;
    exp_v   = exp_q.pop_front();
    check_eq("busy_cycles", busy_n, LATENCY + 1);
    check_eq("rdata", got_rd, exp_v[31:0]);
    check_eq("err", {31'd0, got_err}, {31'd0, exp_v[32]});
    @(posedge clk);
    #1;
    mem_read  = 4'd0;
    mem_write = 3'd0;
    @(negedge clk);
    check_eq("err_one_cycle", {31'd0, mem_err}, 32'd0);
    check_eq("busy_after", {31'd0, mem_busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r;
  logic        e;
  logic [31:0] saved;

  initial begin
    int          kind;
    logic [3:0]  rd_v;
    logic [2:0]  wr_v;
    logic [31:0] addr;
    logic [2:0]  good_f3 [5];
    good_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset and idle
    rst_n     = 1'b0;
    mem_read  = 4'd0;
    mem_write = 3'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'd0, mem_busy}, 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_err", {31'd0, mem_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_busy", {31'd0, mem_busy}, 32'd0);
      check_eq("idle_rdata", mem_rdata, 32'd0);
      check_eq("idle_err", {31'd0, mem_err}, 32'd0);
      check_eq("idle_state", {30'd0, dbg_state}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Fill storage so every byte is known to the model
    for (int a = 0; a < DEPTH; a += 4) do_access(4'd0, 3'b110, a, $urandom, 1'b0, r, e);

    // Directed: word round trip and sub-word loads
    do_access(4'd0, 3'b110, 32'h10, 32'hDEAD_BEEF, 1'b0, r, e);
    check_eq("sw_err", {31'd0, e}, 32'd0);
    do_access(4'b1010, 3'd0, 32'h10, 32'd0, 1'b0, r, e);
    check_eq("lw_10", r, 32'hDEAD_BEEF);
    do_access(4'b1000, 3'd0, 32'h10, 32'd0, 1'b0, r, e);
    check_eq("lb_10", r, 32'hFFFF_FFEF);
    do_access(4'b1100, 3'd0, 32'h11, 32'd0, 1'b0, r, e);
    check_eq("lbu_11", r, 32'h0000_00BE);
    do_access(4'b1001, 3'd0, 32'h12, 32'd0, 1'b0, r, e);
    check_eq("lh_12", r, 32'hFFFF_DEAD);
    do_access(4'b1101, 3'd0, 32'h12, 32'd0, 1'b0, r, e);
    check_eq("lhu_12", r, 32'h0000_DEAD);

    // Directed: sub-word stores (upper data bits must be ignored)
    do_access(4'd0, 3'b100, 32'h13, 32'hAAAA_AA55, 1'b0, r, e);
    check_eq("sb_keeps_rdata", r, 32'h0000_DEAD);
    do_access(4'd0, 3'b101, 32'h10, 32'hFFFF_1234, 1'b0, r, e);
    do_access(4'b1010, 3'd0, 32'h10, 32'd0, 1'b0, r, e);
    check_eq("lw_after_sub", r, 32'h55AD_1234);

    // Directed: misalignment, wrap, unused funct3
    do_access(4'b1010, 3'd0, 32'h11, 32'd0, 1'b0, r, e);
    check_eq("lw_mis_data", r, 32'h55AD_1234);
    check_eq("lw_mis_err", {31'd0, e}, 32'd1);
    do_access(4'b1010, 3'd0, DEPTH + 32'h10, 32'd0, 1'b0, r, e);
    check_eq("lw_wrap_data", r, 32'h55AD_1234);
    check_eq("lw_wrap_err", {31'd0, e}, 32'd0);
    do_access(4'b1011, 3'd0, 32'h10, 32'd0, 1'b0, r, e);
    check_eq("bad_f3_data", r, 32'd0);
    check_eq("bad_f3_err", {31'd0, e}, 32'd1);

    // Randomized traffic, including error cases and mid-access operand changes
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      rd_v = 4'd0;
      wr_v = 3'd0;
      if (kind <= 3)      rd_v = {1'b1, good_f3[$urandom_range(0, 4)]};
      else if (kind <= 6) wr_v = {1'b1, 2'($urandom_range(0, 2))};
      else if (kind == 7) begin
        case ($urandom_range(0, 2))
          0: rd_v = 4'b1011;
          1: rd_v = 4'b1110;
          default: rd_v = 4'b1111;
        endcase
      end
      else if (kind == 8) wr_v = 3'b111;
      else begin
        rd_v = {1'b1, good_f3[$urandom_range(0, 4)]};
        wr_v = {1'b1, 2'($urandom_range(0, 2))};
      end
      addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      do_access(rd_v, wr_v, addr, $urandom, 1'($urandom_range(0, 1)), r, e);
    end

    // Reset in the second WAIT cycle of a store
    do_access(4'b1010, 3'd0, 32'h20, 32'd0, 1'b0, saved, e);
    mem_read  = 4'd0;
    mem_write = 3'b110;
    mem_addr  = 32'h20;
    mem_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("mid_busy_before", {31'd0, mem_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy_fall", {31'd0, mem_busy}, 32'd0);
    check_eq("mid_rdata_rst", mem_rdata, 32'd0);
    check_eq("mid_state_idle", {30'd0, dbg_state}, 32'd0);
    mem_write = 3'd0;
    ref_rdata = 32'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_access(4'b1010, 3'd0, 32'h20, 32'd0, 1'b0, r, e);
    check_eq("mid_mem_kept", r, saved);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory-side responder for the CPU's data memory bus (the READ / WRITE / ADDR / WRITE_DATA / READ_DATA / BUSYWAIT handshake); the CPU is the initiator.
- Byte-addressed, little-endian storage with a configurable access latency.
- Performs RV32 sub-word loads (sign or zero extension) and sub-word stores.
- Drop-in target for the CPU's data port; used in standalone benches and as a latency-model memory.

Parameters:
DEPTH, 1024, storage size in bytes (power of two, at least 4)
LATENCY, 4, clock cycles from request acceptance to completion (1..15)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
DATA_MEM_READ  input  4  bit3 = read request; bits[2:0] = load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
DATA_MEM_WRITE  input  3  bit2 = write request; bits[1:0] = size (00 byte, 01 half, 10 word)
DATA_MEM_ADDR  input  32  byte address
DATA_MEM_WRITE_DATA  input  32  store data, LSB-aligned
DATA_MEM_READ_DATA  output  32  load result, extended to 32 bits
DATA_MEM_BUSYWAIT  output  1  high while a request is pending and not yet complete
DATA_MEM_ERR  output  1  one-cycle pulse coinciding with completion of an erroneous access

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, counter 0, READ_DATA 0, ERR 0, BUSYWAIT 0. Storage contents are not cleared by reset.
- Request detection: req = DATA_MEM_READ[3] | DATA_MEM_WRITE[2].
- BUSYWAIT = req & (state != DONE), combinational. It rises in the same cycle a request appears.
- IDLE:
  - If req, latch ADDR, WRITE_DATA, funct3/size and the direction flag at the edge.
  - Load counter = LATENCY-1, go to WAIT.
- WAIT:
  - Decrement counter each edge.
  - On the edge where counter == 0, perform the access on the latched operands and go to DONE.
- DONE (exactly one cycle):
  - BUSYWAIT low.
  - READ_DATA holds the load result; it is held until the next completed read.
  - ERR is high if the access was erroneous.
  - Always return to IDLE on the next edge.
  - A request still asserted in the IDLE cycle after DONE is treated as a new access. The CPU deasserts its request on the edge where it samples BUSYWAIT low.
- Latency:
  - Request first seen in cycle N.
  - BUSYWAIT is high in cycles N..N+LATENCY.
  - DONE is cycle N+LATENCY+1.
- Address and alignment:
  - Effective address = ADDR mod DEPTH (wraps; no error).
  - Half accesses use address with bit0 cleared; word accesses use address with bits[1:0] cleared.
  - A nonzero dropped bit is a misalignment: the access still proceeds on the aligned address, and ERR pulses.
- Loads:
  - LB / LBU: byte at the effective address, sign-extended (LB) or zero-extended (LBU).
  - LH / LHU: little-endian halfword, sign-extended (LH) or zero-extended (LHU).
  - LW: full word.
  - Unused funct3 (011, 110, 111): READ_DATA = 0, ERR pulses.
- Stores:
  - Byte store writes WRITE_DATA[7:0].
  - Half store writes WRITE_DATA[15:0] little-endian.
  - Word store writes all 4 bytes.
  - Size 11 writes nothing and pulses ERR.
  - Bytes not covered by the store are unchanged.
  - READ_DATA is unchanged by a write.
- Simultaneous read and write request: the write is performed, no read occurs, ERR pulses.
- Request changes mid-access: ignored. Operands were latched in IDLE, and completion still follows the latched operation.
- Request dropped mid-access: the access completes internally. DONE occurs with BUSYWAIT low regardless.
- Reset mid-access:
  - The state machine returns immediately to IDLE and BUSYWAIT falls.
  - An access that had not reached completion leaves memory unmodified.

Test Plan:
- Reset and idle: RESET_N low with no request -> BUSYWAIT=0, READ_DATA=0, ERR=0. Release reset and hold idle 5 cycles -> outputs unchanged.
- Word round-trip: SW 0xDEADBEEF @0x10 with LATENCY=4 -> BUSYWAIT high exactly 5 cycles, ERR=0. Then LW @0x10 -> READ_DATA=0xDEADBEEF.
- Sub-word loads on 0xDEADBEEF @0x10:
  - LB @0x10 -> 0xFFFFFFEF
  - LBU @0x11 -> 0x000000BE
  - LH @0x12 -> 0xFFFFDEAD
  - LHU @0x12 -> 0x0000DEAD
- Sub-word stores: SB 0x55 @0x13 then SH 0x1234 @0x10, then LW @0x10 -> 0x55AD1234.
- Errors and wrap:
  - LW @0x11 -> aligned word @0x10 returned, ERR pulses 1 cycle.
  - LW @(DEPTH+0x10) -> same data as @0x10, ERR=0.
  - DATA_MEM_READ=0b1011 -> READ_DATA=0, ERR pulses.
- Reset mid-access: SW 0xCAFEF00D @0x20 with RESET_N pulsed low in cycle 2 of WAIT -> BUSYWAIT falls immediately. A subsequent LW @0x20 returns the prior contents.
